// File: rtl/core_pkg.sv
// Shared core constants and the operand-fetch bundle carried to execute.
package core_pkg;
  localparam int unsigned XLEN = 64;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;

  typedef struct packed {
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [AW-1:0]   rd;
    logic            rd_we;
  } opfetch_bundle_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard for the register file: one pending-write bit per register, x0 never tracked.
module regfile_scoreboard
  import core_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  input  logic [AW-1:0] rd,
  output logic          rs1_busy,
  output logic          rs2_busy,
  output logic          rd_busy
);

  logic [NREG-1:0] busy_q, busy_d;

  // Clear applied before set so a same-cycle set of the same bit wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en) busy_d[set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign rs1_busy = busy_q[rs1];
  assign rs2_busy = busy_q[rs2];
  assign rd_busy  = busy_q[rd];

endmodule

// File: rtl/regfile_operand_fetch.sv
// Operand-fetch stage: hazard check, operand select and registered bundle to execute.
// Define OPFETCH_BYPASS_EN to forward snooped writeback data straight into the operands.
module regfile_operand_fetch
  import core_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [AW-1:0]   in_rs1_i,
  input  logic [AW-1:0]   in_rs2_i,
  input  logic [AW-1:0]   in_rd_i,
  input  logic            in_rd_we_i,
  output logic [AW-1:0]   rf_read_addr1_o,
  output logic [AW-1:0]   rf_read_addr2_o,
  input  logic [XLEN-1:0] rf_read_data1_i,
  input  logic [XLEN-1:0] rf_read_data2_i,
  input  logic            wb_en_i,
  input  logic [AW-1:0]   wb_addr_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_op1_o,
  output logic [XLEN-1:0] out_op2_o,
  output logic [AW-1:0]   out_rd_o,
  output logic            out_rd_we_o
);

  logic            rs1_busy, rs2_busy, rd_busy;
  logic            bypass1, bypass2;
  logic            hazard, fire;
  logic            out_valid_q;
  opfetch_bundle_t bundle_d, bundle_q;

  assign rf_read_addr1_o = in_rs1_i;
  assign rf_read_addr2_o = in_rs2_i;

`ifdef OPFETCH_BYPASS_EN
  assign bypass1 = wb_en_i && (wb_addr_i == in_rs1_i) && (in_rs1_i != '0);
  assign bypass2 = wb_en_i && (wb_addr_i == in_rs2_i) && (in_rs2_i != '0);
`else
  assign bypass1 = 1'b0;
  assign bypass2 = 1'b0;
`endif

  regfile_scoreboard u_scoreboard (
    .clk      (clk_i),
    .rst      (rst_i),
    .set_en   (fire && in_rd_we_i),
    .set_addr (in_rd_i),
    .clr_en   (wb_en_i),
    .clr_addr (wb_addr_i),
    .rs1      (in_rs1_i),
    .rs2      (in_rs2_i),
    .rd       (in_rd_i),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rd_busy  (rd_busy)
  );

  // The rd term blocks WAW so at most one write per register is ever in flight.
  assign hazard     = (rs1_busy && !bypass1) || (rs2_busy && !bypass2) ||
                      (in_rd_we_i && rd_busy);
  assign in_ready_o = (!out_valid_q || out_ready_i) && !hazard;
  assign fire       = in_valid_i && in_ready_o;

  always_comb begin
    bundle_d       = '0;
    bundle_d.op1   = (in_rs1_i == '0) ? '0 : (bypass1 ? wb_data_i : rf_read_data1_i);
    bundle_d.op2   = (in_rs2_i == '0) ? '0 : (bypass2 ? wb_data_i : rf_read_data2_i);
    bundle_d.rd    = in_rd_i;
    bundle_d.rd_we = in_rd_we_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
    end else if (fire) begin
      out_valid_q <= 1'b1;
      bundle_q    <= bundle_d;
    end else if (out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_op1_o   = bundle_q.op1;
  assign out_op2_o   = bundle_q.op2;
  assign out_rd_o    = bundle_q.rd;
  assign out_rd_we_o = bundle_q.rd_we;

endmodule

// File: doc/regfile_operand_fetch.md
# regfile_operand_fetch

Operand-fetch stage sitting between decode and execute, directly upstream of the 32×64 register file's read ports. It accepts one decoded instruction per cycle over a valid/ready handshake and drives the register file read addresses. It resolves read-after-write and write-after-write hazards with a 32-entry busy scoreboard and presents a registered operand bundle to execute. Writeback traffic is snooped from the register file's write port to clear the scoreboard and, optionally, to bypass operands.

## Interface
Parameters:
- XLEN, 64, operand width
- NREG, 32, architectural register count (x0 hard-wired zero)
- AW, 5, register address width (log2 NREG)

Ports:
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- in_valid_i  in  1  decoded instruction present
- in_ready_o  out  1  stage accepts instruction this cycle
- in_rs1_i, in_rs2_i  in  AW each  source register addresses
- in_rd_i  in  AW  destination register
- in_rd_we_i  in  1  instruction will write in_rd_i
- rf_read_addr1_o, rf_read_addr2_o  out  AW each  to register file read ports (combinational copy of in_rs1_i/in_rs2_i)
- rf_read_data1_i, rf_read_data2_i  in  XLEN each  register file combinational read data
- wb_en_i  in  1  register file write enable (snooped)
- wb_addr_i  in  AW  register file write address (snooped)
- wb_data_i  in  XLEN  register file write data (snooped)
- out_valid_o  out  1  operand bundle valid to execute
- out_ready_i  in  1  execute accepts bundle
- out_op1_o, out_op2_o  out  XLEN each  resolved operands
- out_rd_o  out  AW  destination passthrough
- out_rd_we_o  out  1  write-enable passthrough

## Operation
- Scoreboard: busy[NREG-1:0]; busy[0] is constant 0.
- hazard = (busy[rs1] and not bypass1) or (busy[rs2] and not bypass2) or (in_rd_we_i and busy[rd]).
- bypassN = OPFETCH_BYPASS_EN defined and wb_en_i and wb_addr_i == rsN and rsN != 0.
- in_ready_o = (!out_valid_o or out_ready_i) and !hazard.
- Accept (fire) = in_valid_i and in_ready_o. On fire: register op1/op2, rd, rd_we; out_valid_o ← 1; if in_rd_we_i and rd != 0, set busy[rd].
- Operand select per source: rsN == 0 → 0; bypassN → wb_data_i; else rf_read_dataN_i.
- Output hold: out_valid_o and !out_ready_i → all out_* hold stable. out_ready_i with no fire → out_valid_o ← 0.
- Writeback: wb_en_i and wb_addr_i != 0 clears busy[wb_addr_i]. Writeback to a non-busy register is legal; the clear has no effect.
- Same cycle set and clear of the same bit: set wins. WAW stalls make this reachable only via bypass paths; the rule is still required.
- Writes to x0 are never tracked. Reads of x0 return 0 regardless of rf data.
- States are implicit (EMPTY: out_valid_o=0; FULL: out_valid_o=1). No further FSM.

## Timing
- Latency: 1 cycle from fire to out_valid_o.
- Throughput: 1 instruction/cycle absent hazards and backpressure.
- rf_read_addr* are combinational from inputs. There is no register between the address and the data capture.
- Without bypass, a dependent instruction stalls until the cycle after wb_en_i. Register file writes are synchronous, so the read returns new data then.
- Reset: out_valid_o=0, out_op1_o=out_op2_o=0, out_rd_o=0, out_rd_we_o=0, busy=0. in_ready_o evaluates to 1 once reset is deasserted. Reset asserted mid-operation discards the held bundle and all busy bits immediately.

## Configuration
- OPFETCH_BYPASS_EN defined: writeback-to-operand bypass active. A dependent instruction fires in the same cycle as its producer's writeback.
- Undefined: bypassN tied 0. The dependent instruction fires one cycle after writeback.
- Scoreboard and handshake behaviour are otherwise identical in both builds.

## Structure
- Shared package core_pkg: XLEN, NREG, AW constants; the opfetch_bundle_t struct (op1, op2, rd, rd_we).
- Sub-module regfile_scoreboard: busy vector, set/clear priority, and the two read-busy lookups plus the rd-busy lookup.
- The top level holds the handshake, operand mux and output register.

## Test plan
- Reset then issue rs1=3, rs2=0, rf_data1=0x1234, out_ready_i=1 → next cycle out_valid_o=1, out_op1_o=0x1234, out_op2_o=0.
- Issue rd=5 we=1, then rs1=5 → in_ready_o=0 until writeback. With wb_en_i=1, wb_addr_i=5, wb_data_i=0xAA: bypass build fires that cycle with op1=0xAA; non-bypass build fires the next cycle.
- Issue rd=7 we=1, then rd=7 we=1 (WAW) → second instruction stalls until wb_addr_i=7 is seen.
- Hold out_ready_i=0 for 3 cycles with out_valid_o=1 → outputs stable and in_ready_o=0. Raising out_ready_i → a new bundle is accepted the same cycle.
- Issue rd=0 we=1, then rs1=0 → no stall, op1=0 with rf_data1 driven to all-ones.
- Set busy[9], then assert rst_i mid-stall → out_valid_o=0 and busy cleared immediately. After release, rs1=9 fires without stall.
